// File: rtl/soc_system_position_cmd_out.sv
// Position command output block: an Avalon-MM slave that queues 32-bit
// command words in a small circular FIFO and streams them to the printer
// logic over a valid/ready handshake. It raises a level interrupt when the
// queue is empty and the interrupt is enabled.
module soc_system_position_cmd_out #(
  parameter int         DEPTH      = 4,
  parameter logic [1:0] CTRL_RESET = 2'b00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);

  // Only power-of-two depths 2, 4 and 8 keep the level inside STATUS[7:4].
  if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_bad_depth
    $error("soc_system_position_cmd_out: DEPTH must be 2, 4 or 8");
  end

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   data_rb_q, data_rb_d;
  logic          out_en_q, out_en_d;
  logic          irq_en_q, irq_en_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          irq_q, irq_d;

  logic          bus_wr;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          flush;
  logic          empty;
  logic          full;
  logic [3:0]    level_field;

  assign empty       = (level_q == '0);
  assign full        = (level_q == LVL_FULL);
  assign level_field = 4'(level_q);

  // Stream side: the head entry is presented directly; no fall-through.
  assign out_valid = out_en_q & ~empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign readdata  = readdata_q;
  assign irq       = irq_q;

  // Decode bus writes and FIFO events, then compute all next-state values.
  always_comb begin
    bus_wr   = chipselect & ~write_n;
    push_req = bus_wr & (address == 2'd0);
    push_ok  = push_req & ~full;
    pop      = out_valid & out_ready;
    flush    = bus_wr & (address == 2'd2) & writedata[2];

    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    data_rb_d  = data_rb_q;
    out_en_d   = out_en_q;
    irq_en_d   = irq_en_q;
    readdata_d = 32'h0000_0000;

    if (flush) begin
      // Flush discards the queue and takes precedence over a same-cycle pop.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_ok) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({push_ok, pop})
        2'b10:   level_d = level_q + (AW + 1)'(1);
        2'b01:   level_d = level_q - (AW + 1)'(1);
        default: level_d = level_q;
      endcase
    end

    // A push into a full queue sets the sticky flag, even against a clear.
    if (push_req & full) begin
      overflow_d = 1'b1;
    end else if (bus_wr & (address == 2'd1) & writedata[2]) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    // DATA readback tracks every DATA write, including discarded ones.
    if (push_req) begin
      data_rb_d = writedata;
    end else begin
      data_rb_d = data_rb_q;
    end

    if (bus_wr & (address == 2'd2)) begin
      out_en_d = writedata[0];
      irq_en_d = writedata[1];
    end else begin
      out_en_d = out_en_q;
      irq_en_d = irq_en_q;
    end

    case (address)
      2'd0:    readdata_d = data_rb_q;
      2'd1:    readdata_d = {24'h00_0000, level_field, 1'b0, overflow_q, full, empty};
      2'd2:    readdata_d = {30'h0000_0000, irq_en_q, out_en_q};
      default: readdata_d = 32'h0000_0000;
    endcase

    // Interrupt follows the post-update empty state.
    irq_d = irq_en_d & (level_d == '0);
  end

  // Control and status registers, cleared asynchronously by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      data_rb_q  <= 32'h0000_0000;
      out_en_q   <= CTRL_RESET[0];
      irq_en_q   <= CTRL_RESET[1];
      readdata_q <= 32'h0000_0000;
      irq_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      data_rb_q  <= data_rb_d;
      out_en_q   <= out_en_d;
      irq_en_q   <= irq_en_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  // Command storage; contents are qualified by level so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= writedata;
    end
  end

endmodule

// File: tb/tb_soc_system_position_cmd_out.sv
// Directed bench for soc_system_position_cmd_out: bus writes/reads driven
// from one initial block; accepted commands go into a scoreboard queue and
// are compared against out_data whenever the DUT completes a pop.
module tb_soc_system_position_cmd_out;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  soc_system_position_cmd_out #(.DEPTH(4), .CTRL_RESET(2'b00)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a pop completes at the next rising edge when out_valid and
  // out_ready are both high mid-cycle, unless a flush write is in progress.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready &&
        !(chipselect && !write_n && address == 2'd2 && writedata[2])) begin
      if (exp_q.size() == 0) begin
        check(out_data, 32'hDEAD_BEEF, "unexpected_pop");
      end else begin
        check(out_data, exp_q.pop_front(), "pop_order");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic push(input logic [31:0] d, input bit accepted);
    if (accepted) exp_q.push_back(d);
    bus_write(2'd0, d);
  endtask

  task automatic read_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    tick();
    check(readdata, exp, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(readdata, 32'h0, "reset_readdata");
    check({31'h0, out_valid}, 32'h0, "reset_out_valid");
    check({31'h0, irq}, 32'h0, "reset_irq");
    reset_n = 1'b1;
    check({31'h0, out_valid}, 32'h0, "post_reset_out_valid");
    read_check(2'd1, 32'h0000_0001, "reset_status");
    read_check(2'd0, 32'h0, "reset_data_rb");
    read_check(2'd2, 32'h0, "reset_control");
    read_check(2'd3, 32'h0, "addr3_read");

    // Basic queueing with the stream stalled.
    bus_write(2'd2, 32'h1);
    push(32'hA1, 1'b1);
    push(32'hA2, 1'b1);
    push(32'hA3, 1'b1);
    read_check(2'd1, 32'h0000_0030, "status_level3");
    check(out_data, 32'hA1, "head_a1");
    check({31'h0, out_valid}, 32'h1, "valid_a1");
    read_check(2'd0, 32'hA3, "data_readback");
    bus_write(2'd3, 32'hFFFF_FFFF);
    read_check(2'd3, 32'h0, "addr3_after_write");
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    check(32'(exp_q.size()), 32'h0, "drain_a");
    read_check(2'd1, 32'h0000_0001, "status_empty_a");

    // Overflow: fifth word into a depth-4 queue is dropped.
    push(32'h10, 1'b1);
    push(32'h11, 1'b1);
    push(32'h12, 1'b1);
    push(32'h13, 1'b1);
    read_check(2'd1, 32'h0000_0042, "status_full");
    push(32'h14, 1'b0);
    read_check(2'd1, 32'h0000_0046, "status_overflow");
    out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    check(32'(exp_q.size()), 32'h0, "drain_overflow");
    read_check(2'd1, 32'h0000_0005, "status_sticky_ovf");
    bus_write(2'd1, 32'h4);
    read_check(2'd1, 32'h0000_0001, "status_ovf_clear");

    // Simultaneous push and pop at level 2 across several pointer wraps.
    push(32'hB1, 1'b1);
    push(32'hB2, 1'b1);
    for (int i = 0; i < 12; i++) begin
      out_ready = 1'b1;
      push(32'hB0 + 32'(i), 1'b1);
      out_ready = 1'b0;
      read_check(2'd1, 32'h0000_0020, "status_level2_pushpop");
    end
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check(32'(exp_q.size()), 32'h0, "drain_wrap");

    // Interrupt follows the post-update empty state.
    push(32'hC1, 1'b1);
    push(32'hC2, 1'b1);
    bus_write(2'd2, 32'h3);
    check({31'h0, irq}, 32'h0, "irq_not_empty");
    out_ready = 1'b1;
    tick();
    check({31'h0, irq}, 32'h0, "irq_level1");
    tick();
    out_ready = 1'b0;
    check({31'h0, irq}, 32'h1, "irq_on_empty");
    tick();
    check({31'h0, irq}, 32'h1, "irq_held");
    push(32'hC0, 1'b1);
    check({31'h0, irq}, 32'h0, "irq_after_push");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({31'h0, irq}, 32'h1, "irq_after_drain");

    // Flush beats a simultaneous pop and leaves readback/overflow intact.
    bus_write(2'd2, 32'h1);
    push(32'hD1, 1'b1);
    push(32'hD2, 1'b1);
    out_ready = 1'b1;
    exp_q.delete();
    bus_write(2'd2, 32'h5);
    check({31'h0, out_valid}, 32'h0, "flush_valid");
    read_check(2'd1, 32'h0000_0001, "status_after_flush");
    out_ready = 1'b0;
    read_check(2'd0, 32'hD2, "flush_keeps_readback");
    read_check(2'd2, 32'h0000_0001, "control_readback");
    push(32'hE0, 1'b1);
    push(32'hE1, 1'b1);
    push(32'hE2, 1'b1);
    push(32'hE3, 1'b1);
    push(32'hE4, 1'b0);
    exp_q.delete();
    bus_write(2'd2, 32'h5);
    read_check(2'd1, 32'h0000_0005, "flush_keeps_ovf");
    bus_write(2'd1, 32'h4);
    read_check(2'd1, 32'h0000_0001, "ovf_cleared");

    // Asynchronous reset in the middle of a cycle with three queued words.
    push(32'hF1, 1'b1);
    push(32'hF2, 1'b1);
    push(32'hF3, 1'b1);
    read_check(2'd1, 32'h0000_0030, "status_before_reset");
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check(readdata, 32'h0, "async_reset_readdata");
    check({31'h0, out_valid}, 32'h0, "async_reset_valid");
    check({31'h0, irq}, 32'h0, "async_reset_irq");
    tick();
    reset_n = 1'b1;
    check({31'h0, out_valid}, 32'h0, "release_valid");
    read_check(2'd1, 32'h0000_0001, "status_after_reset");
    read_check(2'd2, 32'h0, "control_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_system_position_cmd_out.md
SOC_SYSTEM_POSITION_CMD_OUT -- requirements
Module: soc_system_position_cmd_out

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the command FIFO depth; legal values are 2, 4 and 8 only.
REQ-002 The block SHALL have parameter CTRL_RESET, default 0, giving the CONTROL[1:0] reset value.
REQ-003 clk  input  1  Avalon and stream clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 address  input  2  Avalon-MM slave word address.
REQ-006 chipselect  input  1  Avalon-MM slave select.
REQ-007 write_n  input  1  Avalon-MM write strobe, active-low; a write occurs when chipselect=1 and write_n=0.
REQ-008 writedata  input  32  Avalon-MM write data.
REQ-009 readdata  output  32  registered Avalon-MM read data.
REQ-010 out_data  output  32  command word at the FIFO head.
REQ-011 out_valid  output  1  out_data holds a valid command.
REQ-012 out_ready  input  1  the printer logic accepts the command.
REQ-013 irq  output  1  level interrupt, asserted when empty and enabled.

Function
REQ-014 Register map:
- addr0 DATA: a write pushes writedata; a read returns the last word written, or 0 if no write since reset.
- addr1 STATUS: bit0 empty, bit1 full, bit2 overflow (sticky), bits[7:4] level, all other bits 0.
- addr2 CONTROL: bit0 out_en, bit1 irq_en, bit2 flush (write-only, self-clearing, reads 0).
- addr3: reads 0; writes are ignored.
REQ-015 readdata SHALL be updated every cycle from the address mux, with no read strobe, and is valid 1 cycle after address is presented.
REQ-016 The FIFO SHALL be a circular buffer with rd_ptr and wr_ptr of log2(DEPTH) bits each, plus a level counter of log2(DEPTH)+1 bits.
REQ-017 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-018 empty = (level==0) and full = (level==DEPTH).
REQ-019 out_valid SHALL equal out_en AND NOT empty, combinationally.
REQ-020 out_data SHALL be the entry at rd_ptr, combinationally; its value when out_valid=0 is don't-care.
REQ-021 A pop SHALL occur in a cycle where out_valid=1 and out_ready=1: rd_ptr increments and level decrements at the next edge.
REQ-022 While out_valid=1, out_data SHALL stay stable until a pop occurs.
REQ-023 A push (DATA write) while not full SHALL store writedata at wr_ptr; wr_ptr and level increment at the next edge.
REQ-024 A push while full SHALL discard the data and set overflow, even if a pop occurs in the same cycle; in that case the pop still completes.
REQ-025 A push and pop in the same cycle (not full, not empty) SHALL leave level unchanged and advance both pointers.
REQ-026 A push into an empty FIFO SHALL assert out_valid in the next cycle (if out_en=1); there is no fall-through in the same cycle.
REQ-027 A STATUS write with writedata[2]=1 SHALL clear overflow; if an overflowing push occurs in the same cycle, set wins.
REQ-028 A CONTROL write SHALL load out_en and irq_en from writedata[1:0].
REQ-029 If a CONTROL write has writedata[2]=1, the block SHALL reset rd_ptr, wr_ptr and level to 0 at that edge.
- flush wins over a simultaneous pop.
- overflow and the DATA readback register SHALL be unaffected by flush.
REQ-030 irq SHALL be registered: irq <= irq_en AND empty, using the post-update empty value, so it follows the FIFO state with 1-cycle latency.
REQ-031 Clearing out_en SHALL stall the stream without losing entries; pushes are still accepted.

Reset
REQ-032 On reset_n=0, asynchronously:
- pointers=0, level=0, overflow=0, DATA readback=0;
- out_en/irq_en=CTRL_RESET;
- readdata=0, irq=0.
FIFO storage need not be reset.
REQ-033 Reset asserted mid-transfer SHALL drop all pending commands.
REQ-034 out_valid SHALL be 0 while in reset and in the first cycle after deassertion.

Verification
REQ-035 Write CONTROL=0x1, then push 0xA1,0xA2,0xA3 with out_ready=0 -> STATUS=0x30; out_data=0xA1; out_valid=1.
REQ-036 With DEPTH=4, push 5 words 0x10..0x14 with out_ready=0 -> STATUS=0x42 (full, level 4) then 0x46; drain order is 0x10..0x13; 0x14 is lost.
REQ-037 With level=2 and out_ready=1, push 0xB0 in the same cycle as a pop -> level stays 2; pointers wrap correctly across 3 rounds of 4 entries.
REQ-038 Write CONTROL=0x3, let the FIFO drain -> irq=1 one cycle after empty; push 0xC0 -> irq=0 one cycle later.
REQ-039 Push 2 words, then write CONTROL=0x5 with out_ready=1 -> the next STATUS is 0x01 and no further pop occurs; write STATUS=0x4 after an overflow -> overflow=0.
REQ-040 Assert reset_n=0 asynchronously with level=3 -> readdata=0, out_valid=0 and irq=0 immediately; STATUS reads 0x01 after release.
